// File: rtl/fetch_pipe_controller.sv
// Fetch-pipe control: turns main-pipe flush requests into registered flush commands with a held
// redirect PC, sequences ICache/ITLB invalidation, and merges stage stall requests.
module fetch_pipe_controller #(
    parameter int VADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flushFromMainPipe,
    input  logic [1:0]             flushReason,
    input  logic [VADDR_WIDTH-1:0] flushTargetPcFromMainPipe,
    input  logic                   invalidateITlbDone,
    input  logic                   invalidateICacheDone,
    input  logic                   stallFromICacheReadStage,
    input  logic                   stallFromInsnTraverseStage,
    output logic                   stall,
    output logic                   flush,
    output logic [VADDR_WIDTH-1:0] flushTargetPc,
    output logic                   invalidateITlb,
    output logic                   invalidateICache
);

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_FLUSH         = 2'd1,
        ST_INV_ITLB      = 2'd2,
        ST_INV_ICACHE    = 2'd3
    } state_t;

    localparam logic [1:0] REASON_FENCE_I     = 2'd2;
    localparam logic [1:0] REASON_SFENCE_VMA  = 2'd3;

    state_t                 state_q, state_d;
    logic [VADDR_WIDTH-1:0] flush_target_pc_q, flush_target_pc_d;
    logic                   pending_icache_q, pending_icache_d;
    logic                   pending_itlb_q, pending_itlb_d;

    logic req_icache_inv;
    logic req_itlb_inv;

    assign req_icache_inv = flushFromMainPipe && (flushReason == REASON_FENCE_I);
    assign req_itlb_inv   = flushFromMainPipe && (flushReason == REASON_SFENCE_VMA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            flush_target_pc_q <= '0;
            pending_icache_q  <= 1'b0;
            pending_itlb_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            flush_target_pc_q <= flush_target_pc_d;
            pending_icache_q  <= pending_icache_d;
            pending_itlb_q    <= pending_itlb_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        flush_target_pc_d = flush_target_pc_q;
        pending_icache_d  = pending_icache_q;
        pending_itlb_d    = pending_itlb_q;

        // The latest redirect PC always wins, whatever the current state.
        if (flushFromMainPipe) begin
            flush_target_pc_d = flushTargetPcFromMainPipe;
        end

        case (state_q)
            ST_IDLE, ST_FLUSH: begin
                if (req_icache_inv) begin
                    state_d = ST_INV_ICACHE;
                end else if (req_itlb_inv) begin
                    state_d = ST_INV_ITLB;
                end else if (flushFromMainPipe) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INV_ITLB: begin
                if (req_icache_inv) begin
                    pending_icache_d = 1'b1;
                end
                // A FenceI arriving with done chains straight into the ICache invalidation.
                if (invalidateITlbDone) begin
                    if (pending_icache_q || req_icache_inv) begin
                        state_d          = ST_INV_ICACHE;
                        pending_icache_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_INV_ICACHE: begin
                if (req_itlb_inv) begin
                    pending_itlb_d = 1'b1;
                end
                if (invalidateICacheDone) begin
                    if (pending_itlb_q || req_itlb_inv) begin
                        state_d        = ST_INV_ITLB;
                        pending_itlb_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        flush            = (state_q != ST_IDLE);
        invalidateITlb   = (state_q == ST_INV_ITLB);
        invalidateICache = (state_q == ST_INV_ICACHE);
        flushTargetPc    = flush_target_pc_q;
        stall            = stallFromICacheReadStage | stallFromInsnTraverseStage |
                           invalidateITlb | invalidateICache;
    end

endmodule

// File: tb/tb_fetch_pipe_controller.sv
// Bench for fetch_pipe_controller: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based model of outstanding invalidations.
module tb_fetch_pipe_controller;

    logic        clk;
    logic        rst;
    logic        flushFromMainPipe;
    logic [1:0]  flushReason;
    logic [31:0] flushTargetPcFromMainPipe;
    logic        invalidateITlbDone;
    logic        invalidateICacheDone;
    logic        stallFromICacheReadStage;
    logic        stallFromInsnTraverseStage;
    logic        stall;
    logic        flush;
    logic [31:0] flushTargetPc;
    logic        invalidateITlb;
    logic        invalidateICache;

    fetch_pipe_controller #(.VADDR_WIDTH(32)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .flushFromMainPipe          (flushFromMainPipe),
        .flushReason                (flushReason),
        .flushTargetPcFromMainPipe  (flushTargetPcFromMainPipe),
        .invalidateITlbDone         (invalidateITlbDone),
        .invalidateICacheDone       (invalidateICacheDone),
        .stallFromICacheReadStage   (stallFromICacheReadStage),
        .stallFromInsnTraverseStage (stallFromInsnTraverseStage),
        .stall                      (stall),
        .flush                      (flush),
        .flushTargetPc              (flushTargetPc),
        .invalidateITlb             (invalidateITlb),
        .invalidateICache           (invalidateICache)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model: list of outstanding invalidations (head is the one in progress), 1=ITLB, 2=ICache.
    int          m_q[$];
    bit          m_pulse;
    logic [31:0] m_pc;
    bit          m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_has(input int kind);
        foreach (m_q[i]) if (m_q[i] == kind) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_update();
        bit busy;
        int head;
        int kind;
        if (rst) begin
            m_q.delete();
            m_pulse = 1'b0;
            m_pc    = '0;
            m_valid = 1'b1;
            return;
        end
        busy    = (m_q.size() > 0);
        head    = busy ? m_q[0] : 0;
        m_pulse = 1'b0;
        if (flushFromMainPipe) begin
            m_pc = flushTargetPcFromMainPipe;
            if (flushReason < 2) begin
                if (!busy) m_pulse = 1'b1;
            end else begin
                kind = (flushReason == 2'd2) ? 2 : 1;
                if (!m_has(kind)) m_q.push_back(kind);
            end
        end
        if (busy && ((head == 1 && invalidateITlbDone) || (head == 2 && invalidateICacheDone)))
            void'(m_q.pop_front());
    endtask

    task automatic model_compare();
        bit busy;
        if (!m_valid) return;
        busy = (m_q.size() > 0);
        chk("m_flush", {31'd0, flush}, {31'd0, busy | m_pulse});
        chk("m_pc", flushTargetPc, m_pc);
        chk("m_itlb", {31'd0, invalidateITlb}, {31'd0, busy && m_q[0] == 1});
        chk("m_icache", {31'd0, invalidateICache}, {31'd0, busy && m_q[0] == 2});
        chk("m_stall", {31'd0, stall},
            {31'd0, stallFromICacheReadStage | stallFromInsnTraverseStage | busy});
    endtask

    task automatic tick();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        rst                        = 1'b0;
        flushFromMainPipe          = 1'b0;
        flushReason                = 2'd0;
        flushTargetPcFromMainPipe  = '0;
        invalidateITlbDone         = 1'b0;
        invalidateICacheDone       = 1'b0;
        stallFromICacheReadStage   = 1'b0;
        stallFromInsnTraverseStage = 1'b0;
    endtask

    task automatic request(input logic [1:0] reason, input logic [31:0] pc);
        flushFromMainPipe         = 1'b1;
        flushReason               = reason;
        flushTargetPcFromMainPipe = pc;
    endtask

    task automatic outs(input string tag, input logic f, input logic t, input logic c,
                        input logic s);
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, f});
        chk({tag, "_itlb"}, {31'd0, invalidateITlb}, {31'd0, t});
        chk({tag, "_icache"}, {31'd0, invalidateICache}, {31'd0, c});
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, s});
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outs("rst", 0, 0, 0, 0);
        chk("rst_pc", flushTargetPc, 32'h0);
        stallFromInsnTraverseStage = 1'b1;
        #1;
        chk("stage_stall", {31'd0, stall}, 32'd1);
        stallFromInsnTraverseStage = 1'b0;
        tick();

        // Branch: flush for exactly one cycle with the redirect PC
        request(2'd0, 32'h8000_0100);
        tick();
        quiet();
        outs("br", 1, 0, 0, 0);
        chk("br_pc", flushTargetPc, 32'h8000_0100);
        tick();
        outs("br_end", 0, 0, 0, 0);

        // Back-to-back Trap then Branch
        request(2'd1, 32'h100);
        tick();
        chk("b2b_pc1", flushTargetPc, 32'h100);
        request(2'd0, 32'h200);
        tick();
        quiet();
        chk("b2b_flush2", {31'd0, flush}, 32'd1);
        chk("b2b_pc2", flushTargetPc, 32'h200);
        tick();
        outs("b2b_end", 0, 0, 0, 0);

        // FenceI, ICache done on the fourth busy cycle
        request(2'd2, 32'h40);
        tick();
        quiet();
        for (int i = 0; i < 3; i++) begin
            outs("fi_busy", 1, 0, 1, 1);
            tick();
        end
        outs("fi_busy", 1, 0, 1, 1);
        invalidateICacheDone = 1'b1;
        tick();
        quiet();
        outs("fi_end", 0, 0, 0, 0);

        // SFenceVma, then FenceI while busy, chained after ITLB done
        request(2'd3, 32'h50);
        tick();
        quiet();
        outs("sf_a", 1, 1, 0, 1);
        tick();
        request(2'd2, 32'h300);
        tick();
        quiet();
        outs("sf_b", 1, 1, 0, 1);
        chk("sf_pc", flushTargetPc, 32'h300);
        invalidateITlbDone = 1'b1;
        tick();
        quiet();
        outs("chain_ic", 1, 0, 1, 1);
        chk("chain_pc", flushTargetPc, 32'h300);
        invalidateICacheDone = 1'b1;
        tick();
        quiet();
        outs("chain_end", 0, 0, 0, 0);

        // Minimum-length invalidation: done already high
        request(2'd3, 32'h60);
        invalidateITlbDone = 1'b1;
        tick();
        flushFromMainPipe = 1'b0;
        outs("min_a", 1, 1, 0, 1);
        tick();
        quiet();
        outs("min_end", 0, 0, 0, 0);

        // Reset in the middle of an ICache invalidation, then a stray done
        request(2'd2, 32'h70);
        tick();
        quiet();
        outs("mid", 1, 0, 1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outs("mid_rst", 0, 0, 0, 0);
        chk("mid_rst_pc", flushTargetPc, 32'h0);
        invalidateICacheDone = 1'b1;
        tick();
        quiet();
        outs("stray", 0, 0, 0, 0);

        // Random traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst                        = ($urandom_range(0, 149) == 0);
            flushFromMainPipe          = ($urandom_range(0, 3) == 0);
            flushReason                = 2'($urandom_range(0, 3));
            flushTargetPcFromMainPipe  = $urandom;
            invalidateITlbDone         = ($urandom_range(0, 2) == 0);
            invalidateICacheDone       = ($urandom_range(0, 2) == 0);
            stallFromICacheReadStage   = ($urandom_range(0, 3) == 0);
            stallFromInsnTraverseStage = ($urandom_range(0, 3) == 0);
            tick();
        end
        quiet();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
